// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with a direct-load mode
// and an auto-scan mode that sweeps every output with a programmable dwell.
module decoder_scan #(
  parameter int SEL_W = 4,
  parameter int DWELL_W = 8,
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  localparam int N_OUT = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   binary_in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   decoder_out,
  output logic [SEL_W-1:0]   index_out,
  output logic               wrap,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic [N_OUT-1:0] OFF = {N_OUT{OUT_ACTIVE_LOW}};
  localparam logic [N_OUT-1:0] ONE = {{(N_OUT-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] LAST = {SEL_W{1'b1}};

  state_t state_q;
  state_t state_n;
  logic [SEL_W-1:0] index_n;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_n;
  logic wrap_n;
  logic busy_n;
  logic [N_OUT-1:0] dec_n;

  // Next state, next index, dwell countdown and the decoded pattern.
  always_comb begin
    state_n = state_q;
    index_n = index_out;
    cnt_n = cnt_q;
    wrap_n = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      index_n = '0;
      cnt_n = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mode) begin
            state_n = SCAN;
            index_n = '0;
            cnt_n = dwell;
          end else begin
            state_n = DIRECT;
            index_n = load ? binary_in : '0;
          end
        end
        DIRECT: begin
          if (mode) begin
            state_n = SCAN;
            index_n = '0;
            cnt_n = dwell;
          end else if (load) begin
            index_n = binary_in;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_n = DIRECT;
          end else if (cnt_q == '0) begin
            index_n = index_out + 1'b1;
            cnt_n = dwell;
            wrap_n = (index_out == LAST);
          end else begin
            cnt_n = cnt_q - 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          index_n = '0;
          cnt_n = '0;
        end
      endcase
    end
    busy_n = (state_n != IDLE);
    dec_n = busy_n ? ((ONE << index_n) ^ OFF) : OFF;
  end

  // State and every output are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      index_out <= '0;
      cnt_q <= '0;
      wrap <= 1'b0;
      busy <= 1'b0;
      decoder_out <= OFF;
    end else begin
      state_q <= state_n;
      index_out <= index_n;
      cnt_q <= cnt_n;
      wrap <= wrap_n;
      busy <= busy_n;
      decoder_out <= dec_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: an active-high and an
// active-low instance share stimulus; a monitor checks both.
module tb_decoder_scan;

  typedef struct {
    logic [15:0] dec;
    logic [3:0]  idx;
    logic        wrap;
    logic        busy;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic mode = 1'b0;
  logic load = 1'b0;
  logic [3:0] binary_in = '0;
  logic [7:0] dwell = '0;

  logic [15:0] dec_h;
  logic [3:0] idx_h;
  logic wrap_h;
  logic busy_h;
  logic [15:0] dec_l;
  logic [3:0] idx_l;
  logic wrap_l;
  logic busy_l;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t e;

  decoder_scan #(.SEL_W(4), .DWELL_W(8), .OUT_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .load(load), .binary_in(binary_in), .dwell(dwell),
    .decoder_out(dec_h), .index_out(idx_h), .wrap(wrap_h), .busy(busy_h)
  );

  decoder_scan #(.SEL_W(4), .DWELL_W(8), .OUT_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .load(load), .binary_in(binary_in), .dwell(dwell),
    .decoder_out(dec_l), .index_out(idx_l), .wrap(wrap_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] oh(int i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  task automatic check(string nm, logic [15:0] d, logic [3:0] i,
                       logic w, logic b);
    total++;
    if ({dec_h, idx_h, wrap_h, busy_h} !== {d, i, w, b} ||
        {dec_l, idx_l, wrap_l, busy_l} !== {~d, i, w, b}) begin
      bad++;
      $display("FAIL %s: got dec=%h idx=%h wrap=%b busy=%b dec_al=%h, want dec=%h idx=%h wrap=%b busy=%b dec_al=%h",
               nm, dec_h, idx_h, wrap_h, busy_h, dec_l, d, i, w, b, ~d);
    end
  endtask

  task automatic drive(logic en, logic md, logic ld,
                       logic [3:0] bin, logic [7:0] dw);
    @(negedge clk);
    enable = en;
    mode = md;
    load = ld;
    binary_in = bin;
    dwell = dw;
  endtask

  task automatic push(logic [15:0] d, logic [3:0] i, logic w,
                      logic b, string nm);
    exp_t x;
    x.dec = d;
    x.idx = i;
    x.wrap = w;
    x.busy = b;
    x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: after each edge, compare the outputs with queued expectations.
  always @(posedge clk) begin
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.name, e.dec, e.idx, e.wrap, e.busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check("reset", 16'h0000, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 0, 0, 4'h0, 8'd0);
    push(16'h0000, 4'h0, 0, 0, "idle");

    drive(1, 0, 1, 4'hA, 8'd0);
    push(16'h0400, 4'hA, 0, 1, "direct_A");
    drive(1, 0, 0, 4'h5, 8'd0);
    push(16'h0400, 4'hA, 0, 1, "direct_hold");
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 4'(i), 8'd0);
      push(oh(i), 4'(i), 0, 1, "direct_sweep");
    end
    drive(1, 0, 1, 4'h3, 8'd0);
    push(16'h0008, 4'h3, 0, 1, "direct_3");
    drive(0, 0, 1, 4'h7, 8'd0);
    push(16'h0000, 4'h0, 0, 0, "en_prio_load");

    for (int k = 0; k < 52; k++) begin
      drive(1, 1, 1'(k % 2), 4'hF, 8'd2);
      push(oh((k / 3) % 16), 4'((k / 3) % 16), 1'(k == 48), 1,
           "scan_dw2");
    end

    drive(0, 1, 0, 4'h0, 8'd0);
    push(16'h0000, 4'h0, 0, 0, "idle2");
    for (int k = 0; k < 42; k++) begin
      drive(1, 1, 0, 4'h0, 8'd0);
      push(oh(k % 16), 4'(k % 16), 1'(k == 16 || k == 32), 1,
           "scan_dw0");
    end

    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset_async", 16'h0000, 4'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    push(16'h0001, 4'h0, 0, 1, "post_reset");

    drive(1, 1, 0, 4'h0, 8'd1);
    push(16'h0002, 4'h1, 0, 1, "dw_chg_a");
    drive(1, 1, 0, 4'h0, 8'd3);
    push(16'h0002, 4'h1, 0, 1, "dw_chg_b");
    for (int j = 0; j < 4; j++) begin
      drive(1, 1, 0, 4'h0, 8'd3);
      push(16'h0004, 4'h2, 0, 1, "dw_chg_hold");
    end
    drive(1, 1, 0, 4'h0, 8'd3);
    push(16'h0008, 4'h3, 0, 1, "dw_chg_adv");

    drive(0, 1, 0, 4'h0, 8'd0);
    push(16'h0000, 4'h0, 0, 0, "idle3");
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 0, 4'h0, 8'd0);
      push(oh(k), 4'(k), 0, 1, "scan_to7");
    end
    drive(0, 1, 0, 4'h0, 8'd0);
    push(16'h0000, 4'h0, 0, 0, "en_drop");
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 0, 4'h0, 8'd0);
      push(oh(k), 4'(k), 0, 1, "restart");
    end
    drive(1, 0, 0, 4'h9, 8'd0);
    push(16'h0020, 4'h5, 0, 1, "scan_to_direct");
    for (int j = 0; j < 3; j++) begin
      drive(1, 0, 0, 4'h9, 8'd0);
      push(16'h0020, 4'h5, 0, 1, "direct_retain");
    end
    drive(1, 0, 1, 4'hC, 8'd0);
    push(16'h1000, 4'hC, 0, 1, "direct_C");
    drive(1, 1, 1, 4'h9, 8'd5);
    push(16'h0001, 4'h0, 0, 1, "direct_to_scan");
    drive(1, 1, 0, 4'h9, 8'd5);
    push(16'h0001, 4'h0, 0, 1, "scan_hold");
    drive(0, 0, 0, 4'h0, 8'd0);
    push(16'h0000, 4'h0, 0, 0, "final_idle");

    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL have parameter SEL_W, default 4, giving the select/index width.
REQ-002 The block SHALL have parameter N_OUT, fixed at 2**SEL_W and not overridable, giving the output count.
REQ-003 The block SHALL have parameter DWELL_W, default 8, giving the dwell-count width.
REQ-004 The block SHALL have parameter OUT_ACTIVE_LOW, default 0; when 1, decoder_out is inverted.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk: input, 1 bit, sole clock, rising edge.
REQ-007 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-008 Port enable: input, 1 bit, block run enable.
REQ-009 Port mode: input, 1 bit, 0 = direct decode, 1 = auto-scan.
REQ-010 Port load: input, 1 bit, direct-mode strobe that captures binary_in.
REQ-011 Port binary_in: input, SEL_W bits, select value.
REQ-012 Port dwell: input, DWELL_W bits, scan hold length minus one.
REQ-013 Port decoder_out: output, N_OUT bits, registered one-hot (one-cold when OUT_ACTIVE_LOW=1).
REQ-014 Port index_out: output, SEL_W bits, current registered index.
REQ-015 Port wrap: output, 1 bit, one-cycle pulse on scan wrap-around.
REQ-016 Port busy: output, 1 bit, high when state is not IDLE.

Function
REQ-017 The block SHALL implement the states IDLE, DIRECT and SCAN.
REQ-018 decoder_out SHALL equal one-hot(index) in DIRECT and SCAN, and all-inactive in IDLE (0 for active-high, all ones for active-low).
REQ-019 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-020 IDLE SHALL move to DIRECT when enable=1 and mode=0, and to SCAN when enable=1 and mode=1.
REQ-021 From any state, enable=0 at an edge SHALL move to IDLE: index cleared to 0, dwell counter cleared, decoder_out inactive, wrap=0.
REQ-022 In DIRECT, load=1 at an edge SHALL set index to binary_in, with decoder_out updated at that same edge (1-cycle latency).
REQ-023 A load asserted at the same edge as the IDLE-to-DIRECT transition SHALL be honoured.
REQ-024 In DIRECT without load, index and decoder_out SHALL hold.
REQ-025 On entering DIRECT without load, the block SHALL show index 0 from IDLE, or the retained scan index from SCAN.
REQ-026 On entering SCAN (from IDLE or DIRECT), index SHALL be set to 0 and the dwell counter loaded with dwell.
REQ-027 In SCAN, each index SHALL be held for dwell+1 cycles; dwell=0 SHALL advance the index every cycle.
REQ-028 In SCAN, the dwell counter SHALL decrement each cycle; at 0 the index SHALL advance and the counter SHALL reload with the current dwell value.
REQ-029 A dwell change mid-hold SHALL take effect only at the next reload.
REQ-030 The scan index SHALL increment modulo N_OUT.
REQ-031 On the N_OUT-1 to 0 transition, wrap SHALL be 1 for exactly the first cycle in which index=0; wrap SHALL be 0 in all other cycles and states.
REQ-032 In SCAN, load SHALL be ignored.
REQ-033 mode 1 to 0 while in SCAN SHALL move to DIRECT at the next edge, retaining the index.
REQ-034 mode 0 to 1 while in DIRECT SHALL move to SCAN at the next edge, restarting the index at 0.
REQ-035 enable=0 SHALL take priority over mode and load.

Reset
REQ-036 rst_n=0 SHALL immediately, without a clock, force: state IDLE, index_out=0, dwell counter=0, wrap=0, busy=0, decoder_out inactive.
REQ-037 Reset asserted mid-scan or mid-load SHALL discard all operation in progress.
REQ-038 After rst_n deasserts, the first active edge SHALL be evaluated as IDLE.

Verification
REQ-039 Bench case, reset: scan running at index 9, pulse rst_n low between edges -> decoder_out=0x0000, index_out=0 and busy=0 before the next edge.
REQ-040 Bench case, direct: SEL_W=4, enable=1, mode=0, load=1, binary_in=0xA -> decoder_out=0x0400 and index_out=0xA after the edge; sweep 0x0..0xF and check all 16 one-hot codes.
REQ-041 Bench case, scan with dwell=2: outputs 0x0001, 0x0002, ..., 0x8000, each for 3 cycles; on cycle 49, 0x0001 with wrap=1 for 1 cycle.
REQ-042 Bench case, scan with dwell=0: output advances every cycle; wrap every 16 cycles; dwell changed to 3 mid-hold takes effect only at the next advance.
REQ-043 Bench case, enable/mode changes: enable dropped at scan index 7 -> next edge 0x0000, busy=0; re-enabled -> restart at 0x0001. Also, mode 1 to 0 at index 5 -> DIRECT holds 0x0020 until a load.
REQ-044 Bench case, active-low: OUT_ACTIVE_LOW=1 -> IDLE shows 0xFFFF; direct load of 3 gives 0xFFF7.
